alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; all arithmetic rules below are stated for 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 firstVal  input  32  operand A (rs value after forwarding).
REQ-005 secondVal  input  32  operand B (rt value, or sign-extended immediate for I-type).
REQ-006 func  input  6  R-type function field.
REQ-007 opcode  input  6  instruction opcode.
REQ-008 sa  input  5  shift amount field.
REQ-009 result  output  32  registered operation result.
REQ-010 zeroFlag  output  1  registered branch-condition flag.
REQ-011 overflow  output  1  registered signed-overflow flag.

Function
REQ-012 Inputs SHALL be decoded and evaluated combinationally; result, zeroFlag and overflow SHALL be registered on rising clk, giving a latency of exactly 1 cycle from operand capture to output.
REQ-013 R-type (opcode 000000) ops by func: add 100000 and addu 100001 compute A+B; sub 100010 and subu 100011 compute A-B; and 100100, or 100101, xor 100110, nor 100111.
REQ-014 R-type ops by func (continued): slt 101010 signed compare, sltu 101011 unsigned compare, each giving 1 or 0.
REQ-015 R-type shifts by func: sll 000000 computes B<<sa; srl 000010 computes B>>sa logical; sra 000011 computes B>>>sa arithmetic.
REQ-016 R-type variable shifts by func: sllv 000100, srlv 000110 and srav 000111 use A[4:0] as the shift amount applied to B.
REQ-017 jr (func 001000) SHALL give result = A.
REQ-018 I-type arithmetic ops by opcode: addi 001000 and addiu 001001 compute A+B; slti 001010 signed compare; sltiu 001011 unsigned compare.
REQ-019 I-type logical ops by opcode: andi 001100, ori 001101 and xori 001110 SHALL use the zero-extended B[15:0], ignoring B[31:16].
REQ-020 lui 001111 SHALL give result = {B[15:0], 16'h0}.
REQ-021 lw 100011 and sw 101011 SHALL give result = A+B (address), with wrap-around mod 2^32.
REQ-022 beq 000100 SHALL give result = A-B and zeroFlag = (A==B).
REQ-023 bne 000101 SHALL give result = A-B and zeroFlag = (A!=B), so that a branch is taken iff zeroFlag=1.
REQ-024 For all non-branch ops, zeroFlag SHALL equal (result==0).
REQ-025 j 000010, jal 000011 and any undefined opcode/func SHALL give result 0, zeroFlag 0 and overflow 0.
REQ-026 overflow SHALL be set only for add, addi and sub on signed overflow (operand signs rule); it SHALL be 0 for all other ops. Result SHALL still be the wrapped sum; overflow SHALL never trap.
REQ-027 Shift amounts of 0 SHALL pass B unchanged; an amount of 31 SHALL be legal.
REQ-028 The all-ones finish instruction word (opcode 111111) SHALL be treated as undefined (REQ-025).

Reset
REQ-029 While rst_n=0, result SHALL be 0, zeroFlag 0 and overflow 0, asynchronously and independently of clk.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight result; the first rising clk after release SHALL register the current inputs.

Structure
REQ-031 A shared package SHALL hold the opcode and func localparams and DATA_W; the control unit SHALL use the same package.
REQ-032 The design SHALL be a single module with no sub-modules: a combinational decode/compute block plus one output register.

Verification
REQ-033 add: A=32'h7FFFFFFF, B=1 -> after 1 clk, result=32'h80000000, overflow=1, zeroFlag=0; the same operands with addu -> overflow=0.
REQ-034 beq: A=5, B=5 -> zeroFlag=1, result=0; bne with the same operands -> zeroFlag=0; bne with A=5, B=6 -> zeroFlag=1.
REQ-035 sra: B=32'h80000000, sa=4 -> result=32'hF8000000; srl with the same operands -> 32'h08000000; srav with A=4 -> 32'hF8000000.
REQ-036 slt: A=32'hFFFFFFFF, B=1 -> result=1; sltu with the same operands -> result=0; andi with B=32'hFFFF8001 and A=32'hFFFFFFFF -> result=32'h00008001.
REQ-037 Reset: drive add 3+4, pulse rst_n low between clock edges -> outputs immediately 0; release -> the next edge gives result=7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and MIPS opcode/func encodings.
// Imported by the ALU, its bus interface and the control unit.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Signed overflow from operand/result sign bits; for sub pass ~bSign.
    function automatic logic signedOvf(input logic aSign,
                                       input logic bSign,
                                       input logic sSign);
        return (aSign == bSign) && (sSign != aSign);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
interface alu_if;
    import alu_pkg::*;

    logic [DATA_W-1:0] firstVal;
    logic [DATA_W-1:0] secondVal;
    logic [5:0]        func;
    logic [5:0]        opcode;
    logic [4:0]        sa;
    logic [DATA_W-1:0] result;
    logic              zeroFlag;
    logic              overflow;

    modport master (
        output firstVal, secondVal, func, opcode, sa,
        input  result, zeroFlag, overflow
    );

    modport slave (
        input  firstVal, secondVal, func, opcode, sa,
        output result, zeroFlag, overflow
    );

endinterface

// File: rtl/alu.sv
// Single-cycle-latency MIPS ALU: combinational decode/compute,
// one output register with asynchronous active-low reset.
module alu #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    import alu_pkg::*;

    logic [DATA_W-1:0] a, b, sum, diff;
    logic [DATA_W-1:0] lo16, nextRes;
    logic              nextZero, nextOvf;
    logic              defined, isBranch, brCond;

    assign a    = bus.firstVal;
    assign b    = bus.secondVal;
    assign sum  = a + b;
    assign diff = a - b;
    assign lo16 = DATA_W'(b[15:0]);

    always_comb begin
        nextRes  = '0;
        nextOvf  = 1'b0;
        defined  = 1'b1;
        isBranch = 1'b0;
        brCond   = 1'b0;
        unique case (bus.opcode)
            OP_RTYPE: begin
                unique case (bus.func)
                    FN_ADD: begin
                        nextRes = sum;
                        nextOvf = signedOvf(a[DATA_W-1], b[DATA_W-1],
                                            sum[DATA_W-1]);
                    end
                    FN_ADDU: nextRes = sum;
                    FN_SUB: begin
                        nextRes = diff;
                        nextOvf = signedOvf(a[DATA_W-1], ~b[DATA_W-1],
                                            diff[DATA_W-1]);
                    end
                    FN_SUBU: nextRes = diff;
                    FN_AND:  nextRes = a & b;
                    FN_OR:   nextRes = a | b;
                    FN_XOR:  nextRes = a ^ b;
                    FN_NOR:  nextRes = ~(a | b);
                    FN_SLT:  nextRes = DATA_W'($signed(a) < $signed(b));
                    FN_SLTU: nextRes = DATA_W'(a < b);
                    FN_SLL:  nextRes = b << bus.sa;
                    FN_SRL:  nextRes = b >> bus.sa;
                    FN_SRA:  nextRes = $unsigned($signed(b) >>> bus.sa);
                    FN_SLLV: nextRes = b << a[4:0];
                    FN_SRLV: nextRes = b >> a[4:0];
                    FN_SRAV: nextRes = $unsigned($signed(b) >>> a[4:0]);
                    FN_JR:   nextRes = a;
                    default: defined = 1'b0;
                endcase
            end
            OP_ADDI: begin
                nextRes = sum;
                nextOvf = signedOvf(a[DATA_W-1], b[DATA_W-1],
                                    sum[DATA_W-1]);
            end
            OP_ADDIU, OP_LW, OP_SW: nextRes = sum;
            OP_SLTI:  nextRes = DATA_W'($signed(a) < $signed(b));
            OP_SLTIU: nextRes = DATA_W'(a < b);
            OP_ANDI:  nextRes = a & lo16;
            OP_ORI:   nextRes = a | lo16;
            OP_XORI:  nextRes = a ^ lo16;
            OP_LUI:   nextRes = lo16 << 16;
            OP_BEQ: begin
                nextRes  = diff;
                isBranch = 1'b1;
                brCond   = (a == b);
            end
            OP_BNE: begin
                nextRes  = diff;
                isBranch = 1'b1;
                brCond   = (a != b);
            end
            default: defined = 1'b0;
        endcase
        // Jumps and unknown encodings fall to default: all outputs zero.
        nextZero = isBranch ? brCond : (defined && (nextRes == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result   <= '0;
            bus.zeroFlag <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.result   <= nextRes;
            bus.zeroFlag <= nextZero;
            bus.overflow <= nextOvf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at issue, popped one cycle later.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sa;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        o;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_if bus();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic issue(input vec_t v);
        exp_t e;
        bus.opcode    = v.op;
        bus.func      = v.fn;
        bus.sa        = v.sa;
        bus.firstVal  = v.a;
        bus.secondVal = v.b;
        e.r = v.r;
        e.z = v.z;
        e.o = v.o;
        sb.push_back(e);
    endtask

    task automatic advance(output exp_t e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        vec_t v;
        v = '{OP_RTYPE, FN_ADD, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0};
        issue(v);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.result, bus.zeroFlag, bus.overflow} !== 34'h0) begin
            errors++;
            $display("FAIL reset_hold: got r=%h z=%b o=%b want 0/0/0",
                     bus.result, bus.zeroFlag, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        vec_t v[10];
        exp_t e;
        v[0] = '{OP_RTYPE, FN_ADD,  5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1};
        v[1] = '{OP_RTYPE, FN_ADDU, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0};
        v[2] = '{OP_RTYPE, FN_SUB,  5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1};
        v[3] = '{OP_RTYPE, FN_SUBU, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b0};
        v[4] = '{OP_ADDI,  6'd0,    5'd0, 32'd5, 32'hFFFFFFFB, 32'h0, 1'b1, 1'b0};
        v[5] = '{OP_ADDI,  6'd0,    5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1};
        v[6] = '{OP_ADDIU, 6'd0,    5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
        v[7] = '{OP_LW,    6'd0,    5'd0, 32'hFFFFFFF0, 32'h20, 32'h10, 1'b0, 1'b0};
        v[8] = '{OP_SW,    6'd0,    5'd0, 32'h100, 32'h4, 32'h104, 1'b0, 1'b0};
        v[9] = '{OP_RTYPE, FN_ADD,  5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            issue(v[i]);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL arith[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_branch();
        vec_t v[4];
        exp_t e;
        v[0] = '{OP_BEQ, 6'd0, 5'd0, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0};
        v[1] = '{OP_BNE, 6'd0, 5'd0, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0};
        v[2] = '{OP_BNE, 6'd0, 5'd0, 32'd5, 32'd6, 32'hFFFFFFFF, 1'b1, 1'b0};
        v[3] = '{OP_BEQ, 6'd0, 5'd0, 32'd5, 32'd6, 32'hFFFFFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(v[i]);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL branch[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[9];
        exp_t e;
        v[0] = '{OP_RTYPE, FN_SRA,  5'd4,  32'h0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        v[1] = '{OP_RTYPE, FN_SRL,  5'd4,  32'h0, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
        v[2] = '{OP_RTYPE, FN_SRAV, 5'd0,  32'h4, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        v[3] = '{OP_RTYPE, FN_SLL,  5'd31, 32'h0, 32'h1, 32'h80000000, 1'b0, 1'b0};
        v[4] = '{OP_RTYPE, FN_SLL,  5'd0,  32'h0, 32'h1234, 32'h1234, 1'b0, 1'b0};
        v[5] = '{OP_RTYPE, FN_SRLV, 5'd9,  32'hFFFFFFE1, 32'h8, 32'h4, 1'b0, 1'b0};
        v[6] = '{OP_RTYPE, FN_SLLV, 5'd3,  32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
        v[7] = '{OP_RTYPE, FN_SRA,  5'd31, 32'h0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[8] = '{OP_RTYPE, FN_SRL,  5'd31, 32'h0, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            issue(v[i]);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL shift[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_logic_compare();
        vec_t v[10];
        exp_t e;
        v[0] = '{OP_RTYPE, FN_SLT,  5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0};
        v[1] = '{OP_RTYPE, FN_SLTU, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
        v[2] = '{OP_ANDI,  6'd0,    5'd0, 32'hFFFFFFFF, 32'hFFFF8001, 32'h00008001, 1'b0, 1'b0};
        v[3] = '{OP_ORI,   6'd0,    5'd0, 32'h0, 32'hFFFF00F0, 32'h000000F0, 1'b0, 1'b0};
        v[4] = '{OP_XORI,  6'd0,    5'd0, 32'h0000FFFF, 32'hFFFF00FF, 32'h0000FF00, 1'b0, 1'b0};
        v[5] = '{OP_RTYPE, FN_AND,  5'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0};
        v[6] = '{OP_RTYPE, FN_OR,   5'd0, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0};
        v[7] = '{OP_RTYPE, FN_NOR,  5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[8] = '{OP_SLTI,  6'd0,    5'd0, 32'h80000000, 32'h0, 32'h1, 1'b0, 1'b0};
        v[9] = '{OP_SLTIU, 6'd0,    5'd0, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            issue(v[i]);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL logic[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_misc();
        vec_t v[8];
        exp_t e;
        v[0] = '{OP_LUI,   6'd0,      5'd0, 32'h0, 32'hFFFF1234, 32'h12340000, 1'b0, 1'b0};
        v[1] = '{OP_RTYPE, FN_JR,     5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
        v[2] = '{OP_RTYPE, FN_JR,     5'd0, 32'h0, 32'h5, 32'h0, 1'b1, 1'b0};
        v[3] = '{OP_J,     6'd0,      5'd0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0};
        v[4] = '{OP_JAL,   6'd0,      5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        v[5] = '{6'b111111, 6'b111111, 5'd31, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0};
        v[6] = '{OP_RTYPE, 6'b001111, 5'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0};
        v[7] = '{OP_RTYPE, FN_XOR,    5'd0, 32'h1234ABCD, 32'h1234ABCD, 32'h0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue(v[i]);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL misc[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t   v;
        exp_t   e;
        longint sa64, sb64, s;
        int     k;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 3);
            v.op = OP_RTYPE;
            v.sa = 5'd0;
            v.fn = (k == 0) ? FN_ADD : (k == 1) ? FN_ADDU :
                   (k == 2) ? FN_SUB : FN_SUBU;
            v.a = $urandom;
            v.b = $urandom;
            if (i % 6 == 0) v.b = (k < 2) ? (32'h0 - v.a) : v.a;
            if (i % 6 == 3) v.a = 32'h80000000;
            sa64 = longint'($signed(v.a));
            sb64 = longint'($signed(v.b));
            s = (k < 2) ? (sa64 + sb64) : (sa64 - sb64);
            v.r = s[31:0];
            v.z = (v.r == 32'h0);
            v.o = ((k == 0) || (k == 2)) &&
                  ((s > 64'sd2147483647) || (s < -64'sd2147483648));
            issue(v);
            advance(e);
            checks++;
            if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
                errors++;
                $display("FAIL b2b[%0d] fn=%b a=%h b=%h: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                         i, v.fn, v.a, v.b, bus.result, bus.zeroFlag,
                         bus.overflow, e.r, e.z, e.o);
            end
        end
    endtask

    task automatic test_reset_midop();
        vec_t v;
        exp_t e;
        v = '{OP_RTYPE, FN_OR, 5'd0, 32'hAAAA, 32'h0, 32'hAAAA, 1'b0, 1'b0};
        issue(v);
        advance(e);
        checks++;
        if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
            errors++;
            $display("FAIL midop_prime: got r=%h want r=%h", bus.result, e.r);
        end
        v = '{OP_RTYPE, FN_ADD, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0};
        issue(v);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.result, bus.zeroFlag, bus.overflow} !== 34'h0) begin
            errors++;
            $display("FAIL midop_async_clear: got r=%h z=%b o=%b want 0/0/0",
                     bus.result, bus.zeroFlag, bus.overflow);
        end
        #1;
        rst_n = 1'b1;
        advance(e);
        checks++;
        if ({bus.result, bus.zeroFlag, bus.overflow} !== {e.r, e.z, e.o}) begin
            errors++;
            $display("FAIL midop_release: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                     bus.result, bus.zeroFlag, bus.overflow, e.r, e.z, e.o);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_shift();
        test_logic_compare();
        test_misc();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
